// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the round-robin arbiter and the FIFO.
// The arbiter owns the master modport; the producer/FIFO side uses slave.
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4
);
   localparam int OW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            i_req;
   logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
   logic [NUM_REQ-1:0]            o_ack;
   logic                          i_Full_Flag;
   logic                          o_wr_en;
   logic [DATA_WIDTH-1:0]         o_wr_data;
   logic [OW-1:0]                 o_owner;
   logic                          o_busy;

   modport master (
      input  i_req, i_req_data, i_Full_Flag,
      output o_ack, o_wr_en, o_wr_data, o_owner, o_busy
   );

   modport slave (
      output i_req, i_req_data, i_Full_Flag,
      input  o_ack, o_wr_en, o_wr_data, o_owner, o_busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bounded bursts and never writing while the FIFO is full.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic             i_clk,
   input  logic             i_RST,
   fifo_wr_arbiter_if.master bus
);
   localparam int OW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]            state;
   logic [OW-1:0]         owner;
   logic [OW-1:0]         last_owner;
   logic [OW-1:0]         pick;
   logic [OW:0]           idx;
   logic                  found;
   logic [BW-1:0]         beat_cnt;
   logic                  transfer;
   logic                  release_now;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [NUM_REQ-1:0]    ack;

   // Search upward from last_owner+1 with an explicit wrap so any NUM_REQ works.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = {1'b0, last_owner} + (OW+1)'(i);
         if (idx >= (OW+1)'(NUM_REQ)) idx = idx - (OW+1)'(NUM_REQ);
         if (!found && bus.i_req[idx[OW-1:0]]) begin
            pick  = idx[OW-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (owner == OW'(k)) sel_data = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Reset gates the transfer so the word in flight during reset is never written.
   assign transfer    = (state == GRANT) & bus.i_req[owner] & ~bus.i_Full_Flag & ~i_RST;
   assign release_now = ~bus.i_req[owner] | (transfer & (beat_cnt == BW'(MAX_BURST - 1)));

   always_comb begin
      ack = '0;
      if (transfer) ack[owner] = 1'b1;
   end

   assign bus.o_wr_en   = transfer;
   assign bus.o_ack     = ack;
   assign bus.o_wr_data = transfer ? sel_data : '0;
   assign bus.o_owner   = owner;
   assign bus.o_busy    = (state == GRANT);

   always_ff @(posedge i_clk) begin
      if (i_RST) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OW'(NUM_REQ - 1);
         beat_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.i_req) begin
                  owner    <= pick;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (transfer) beat_cnt <= beat_cnt + BW'(1);
               if (release_now) begin
                  state      <= IDLE;
                  last_owner <= owner;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized self-checking bench: a burst/round-robin reference model predicts
// every output each cycle, with directed phases for reset, stall and release cases.
module tb_fifo_wr_arbiter;
   localparam int DW = 8;
   localparam int NR = 4;
   localparam int MB = 4;

   logic clk;
   logic rst;

   fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
      .i_clk(clk),
      .i_RST(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecCount  = 0;
   int missCount = 0;

   // Producer word counters: each pops to its next word when acked.
   logic [DW-1:0] pdata [NR];

   // Reference model: a grant is "busy with wordsLeft remaining" for one owner.
   logic       mBusy;
   logic [1:0] mOwner;
   logic [1:0] mLast;
   int         mLeft;
   logic       mFresh;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mBusy  = 1'b0;
      mOwner = 2'd0;
      mLast  = 2'(NR - 1);
      mLeft  = MB;
      mFresh = 1'b1;
   endtask

   task automatic applyStimulus(input logic [NR-1:0] reqIn, input logic fullIn, input logic rstIn);
      logic          expXfer;
      logic [NR-1:0] expAck;
      logic [DW-1:0] expData;
      logic          found;
      logic [1:0]    cand;
      bus.i_req       = reqIn;
      bus.i_Full_Flag = fullIn;
      rst             = rstIn;
      bus.i_req_data  = {pdata[3], pdata[2], pdata[1], pdata[0]};
      @(negedge clk);
      expXfer = mBusy && reqIn[mOwner] && !fullIn && !rstIn;
      expAck  = expXfer ? (NR'(1) << mOwner) : '0;
      expData = expXfer ? pdata[mOwner] : '0;
      checkOutput("wr_en", 32'(bus.o_wr_en), 32'(expXfer));
      checkOutput("ack", 32'(bus.o_ack), 32'(expAck));
      checkOutput("wr_data", 32'(bus.o_wr_data), 32'(expData));
      checkOutput("busy", 32'(bus.o_busy), 32'(mBusy));
      if (mBusy || mFresh) checkOutput("owner", 32'(bus.o_owner), 32'(mOwner));
      @(posedge clk);
      if (expXfer) pdata[mOwner] = pdata[mOwner] + 8'd1;
      if (rstIn) begin
         modelReset();
      end else if (!mBusy) begin
         if (reqIn != '0) begin
            found = 1'b0;
            for (int j = 1; j <= NR; j++) begin
               cand = 2'((int'(mLast) + j) % NR);
               if (!found && reqIn[cand]) begin
                  mOwner = cand;
                  found  = 1'b1;
               end
            end
            mBusy  = 1'b1;
            mLeft  = MB;
            mFresh = 1'b0;
         end
      end else if (!reqIn[mOwner]) begin
         mBusy = 1'b0;
         mLast = mOwner;
      end else if (expXfer) begin
         mLeft = mLeft - 1;
         if (mLeft == 0) begin
            mBusy = 1'b0;
            mLast = mOwner;
         end
      end
      #1;
   endtask

   task automatic resetDut();
      repeat (2) applyStimulus(4'b1111, 1'b0, 1'b1);
   endtask

   initial begin
      logic [NR-1:0] r;
      pdata[0] = 8'h01;
      pdata[1] = 8'h41;
      pdata[2] = 8'h81;
      pdata[3] = 8'hC1;
      bus.i_req       = '0;
      bus.i_req_data  = '0;
      bus.i_Full_Flag = 1'b0;
      rst             = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      modelReset();

      $display("[TB] reset hold and single producer");
      resetDut();
      repeat (12) applyStimulus(4'b0100, 1'b0, 1'b0);

      $display("[TB] round robin, all requesting");
      resetDut();
      repeat (25) applyStimulus(4'b1111, 1'b0, 1'b0);

      $display("[TB] full stall mid-burst");
      resetDut();
      repeat (3) applyStimulus(4'b0010, 1'b0, 1'b0);
      repeat (5) applyStimulus(4'b0010, 1'b1, 1'b0);
      repeat (4) applyStimulus(4'b0010, 1'b0, 1'b0);

      $display("[TB] early release");
      resetDut();
      repeat (2) applyStimulus(4'b1100, 1'b0, 1'b0);
      repeat (4) applyStimulus(4'b1000, 1'b0, 1'b0);

      $display("[TB] reset mid-burst");
      resetDut();
      repeat (3) applyStimulus(4'b0001, 1'b0, 1'b0);
      applyStimulus(4'b0001, 1'b0, 1'b1);
      repeat (4) applyStimulus(4'b0011, 1'b0, 1'b0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 1500; n++) begin
         for (int k = 0; k < NR; k++) r[k] = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) r = r & NR'($urandom_range(0, 15));
         applyStimulus(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the FIFO between NUM_REQ producers in the write-clock domain. Each producer presents a request and a data word. The arbiter grants one owner at a time for a bounded burst and drives the FIFO's wr_en/wr_data directly. It honours the FIFO full flag, so no word is ever written into a full FIFO and no word is lost.

Parameters:
DATA_WIDTH, 8, width of each data word (matches FIFO DATA_WIDTH)
NUM_REQ, 4, number of producers (2..8)
MAX_BURST, 4, maximum words accepted from one owner per grant (1..15)

Ports:
i_clk  input  1  write-domain clock (the FIFO i_clk_write)
i_RST  input  1  synchronous, active-high reset
i_req  input  NUM_REQ  per-producer request; bit k high = producer k has a valid word
i_req_data  input  NUM_REQ*DATA_WIDTH  packed words; producer k at bits [k*DATA_WIDTH +: DATA_WIDTH]
o_ack  output  NUM_REQ  one-hot; bit k high = producer k's word is consumed this cycle
i_Full_Flag  input  1  FIFO full flag
o_wr_en  output  1  FIFO write enable
o_wr_data  output  DATA_WIDTH  FIFO write data
o_owner  output  $clog2(NUM_REQ)  index of the current owner (valid when o_busy=1)
o_busy  output  1  a grant is active (state GRANT)

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of i_clk. It takes effect whenever asserted, including mid-burst, and the word in flight that cycle is not written.
- Reset state: IDLE; o_wr_en=0, o_ack=0, o_busy=0, o_owner=0, o_wr_data=0, beat_cnt=0, last_owner=NUM_REQ-1 (so producer 0 has first priority).
- FSM states: IDLE and GRANT.
- IDLE:
  - If i_req is nonzero, pick the first set bit searching from last_owner+1 upward, modulo NUM_REQ.
  - Register the pick as owner, clear beat_cnt, go to GRANT on the next edge.
  - Arbitration costs exactly 1 idle cycle.
  - If i_req is zero, stay in IDLE.
- GRANT (o_busy=1, o_owner=owner):
  - transfer = i_req[owner] & ~i_Full_Flag; this is combinational in the same cycle.
  - o_wr_en = transfer.
  - o_ack = transfer one-hot at owner.
  - o_wr_data = i_req_data slice of owner; it is driven as 0 when transfer=0.
  - The producer treats o_ack as the pop of its word and presents its next word (or drops req) on the next cycle.
  - On transfer, beat_cnt increments.
  - Release to IDLE at the edge where either:
    - (a) i_req[owner]=0, or
    - (b) a transfer occurs with beat_cnt==MAX_BURST-1.
  - On release, last_owner is set to owner.
- Full stall: while i_Full_Flag=1 in GRANT, there is no write and no ack. beat_cnt and owner hold; no timeout.
- Dropping req during a stall releases the grant per (a). A zero-beat grant still updates last_owner.
- Requests from non-owners are ignored until the next IDLE cycle. A request rising mid-burst waits at most MAX_BURST transfers plus 1 arbitration cycle per earlier owner.
- Simultaneous events:
  - Release and new requests on the same edge: the new requests are arbitrated in the following IDLE cycle.
  - The released owner, still requesting, has the lowest priority.
- Single requester: it re-wins after each 1-cycle IDLE bubble. Sustained throughput is MAX_BURST/(MAX_BURST+1).
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - Owner and last_owner are $clog2(NUM_REQ) bits; wrap from NUM_REQ-1 to 0 is explicit (no reliance on power-of-two NUM_REQ).
- Invariants:
  - o_ack is never multi-hot.
  - o_wr_en equals |o_ack.
  - o_wr_en is never 1 while i_Full_Flag=1.

Test Plan:
- Reset: hold i_RST=1 for 2 cycles with i_req=4'b1111 -> o_wr_en=0, o_ack=0, o_busy=0 throughout. First grant after release of reset goes to owner 0.
- Single producer: i_req=4'b0100 held, data 1,2,3,...; full=0 -> writes 1..4 on 4 consecutive cycles with o_ack=4'b0100. Then 1 idle cycle, then writes 5..8.
- Round-robin: all four request continuously; each has data 8'hA0+k -> grant order 0,1,2,3,0. Each burst is 4 writes of its word. One idle cycle between bursts, and no producer writes twice in a row.
- Full stall: producer 1 granted; raise i_Full_Flag after 2 writes for 5 cycles -> o_wr_en=0 and o_ack=0 during the stall; owner is still 1. After full drops, exactly 2 more writes, then release.
- Early release: producer 2 drops i_req after 1 write while producer 3 requests -> producer 2's grant ends after 1 beat. IDLE for 1 cycle, then producer 3 is granted.
- Reset mid-burst: assert i_RST in the 3rd beat of producer 0's burst -> no write that cycle, outputs return to reset values. Next grant starts from producer 0 again.
